// File: rtl/dtc_rr_sched.sv
// Round-robin front end that time-shares one combinational decision-tree classifier
// among N_REQ requesters and returns each result with its requester ID.
module dtc_rr_sched #(
  parameter int N_REQ = 4,
  parameter int IN_W  = 7,
  parameter int OUT_W = 10,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*IN_W-1:0] req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic [IN_W-1:0]       clf_inp,
  input  logic [OUT_W-1:0]      clf_outp,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [OUT_W-1:0]      rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy,
  output logic [CNT_W-1:0]      done_cnt
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t          state, state_next;
  logic [ID_W-1:0] ptr, id_q, winner, ptr_next, idx;
  logic            found, grant_en;
  logic [IN_W-1:0] feat [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign feat[gi]      = req_data[gi*IN_W +: IN_W];
      assign req_ready[gi] = grant_en && (int'(winner) == gi);
    end
  endgenerate

  // First valid requester at or above ptr, wrapping modulo N_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign ptr_next  = ID_W'((int'(winner) + 1) % N_REQ);
  assign grant_en  = !rst && found &&
                     ((state == IDLE) || ((state == RESP) && rsp_ready));
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_en) state_next = EVAL;
      EVAL:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = grant_en ? EVAL : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      id_q     <= '0;
      clf_inp  <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
      done_cnt <= '0;
    end else begin
      state <= state_next;
      if (grant_en) begin
        clf_inp <= feat[winner];
        id_q    <= winner;
        ptr     <= ptr_next;
      end
      // clf_inp has been stable for the whole EVAL cycle, so the result is settled.
      if (state == EVAL) begin
        rsp_data <= clf_outp;
        rsp_id   <= id_q;
      end
      if ((state == RESP) && rsp_ready)
        done_cnt <= done_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dtc_rr_sched.sv
// Directed bench for dtc_rr_sched with a pass-through classifier model and a 4-bit counter.
module tb_dtc_rr_sched;
  localparam int N_REQ = 4;
  localparam int IN_W  = 7;
  localparam int OUT_W = 10;
  localparam int ID_W  = 2;
  localparam int CNT_W = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*IN_W-1:0] req_data;
  logic [N_REQ-1:0]      req_ready;
  logic [IN_W-1:0]       clf_inp;
  logic [OUT_W-1:0]      clf_outp;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [OUT_W-1:0]      rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic                  busy;
  logic [CNT_W-1:0]      done_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign clf_outp = {3'b000, clf_inp};

  dtc_rr_sched #(.N_REQ(N_REQ), .IN_W(IN_W), .OUT_W(OUT_W), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .clf_inp(clf_inp), .clf_outp(clf_outp), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy), .done_cnt(done_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    req_data = {7'h04, 7'h03, 7'h02, 7'h01};
    rsp_ready = 1'b1;
    tick();
    tick();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags got valid=%b busy=%b exp 0 0", rsp_valid, busy); end
    checks++; if (clf_inp !== 7'h00 || rsp_data !== 10'h000 || rsp_id !== 2'd0) begin errors++; $display("FAIL reset_data got inp=%h data=%h id=%0d exp 0", clf_inp, rsp_data, rsp_id); end
    checks++; if (done_cnt !== 4'd0) begin errors++; $display("FAIL reset_done_cnt got %0d exp 0", done_cnt); end
    req_valid = '0;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single();
    req_data = {7'h00, 7'h05, 7'h00, 7'h00};
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got %b exp 0100", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (req_ready !== 4'b0000 || busy !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_eval got rdy=%b busy=%b valid=%b exp 0000 1 0", req_ready, busy, rsp_valid); end
    checks++; if (clf_inp !== 7'h05) begin errors++; $display("FAIL single_clf_inp got %h exp 05", clf_inp); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 10'h005 || rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp got valid=%b data=%h id=%0d exp 1 005 2", rsp_valid, rsp_data, rsp_id); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== 4'd1) begin errors++; $display("FAIL single_done got valid=%b busy=%b cnt=%0d exp 0 0 1", rsp_valid, busy, done_cnt); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    logic [9:0] exp_data;
    do_reset();
    req_data = {7'h04, 7'h03, 7'h02, 7'h01};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int g = 0; g < 6; g++) begin
      exp_rdy = 4'b0001 << (g % 4);
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", g, req_ready, exp_rdy); end
      if (g > 0) begin
        exp_data = 10'((g - 1) % 4 + 1);
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_id !== 2'((g - 1) % 4)) begin errors++; $display("FAIL rr_rsp%0d got valid=%b data=%h id=%0d exp 1 %h %0d", g, rsp_valid, rsp_data, rsp_id, exp_data, (g - 1) % 4); end
      end
      tick();
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0000) begin errors++; $display("FAIL rr_eval%0d got valid=%b busy=%b rdy=%b exp 0 1 0000", g, rsp_valid, busy, req_ready); end
      tick();
    end
    checks++; if (rsp_data !== 10'h002 || rsp_id !== 2'd1) begin errors++; $display("FAIL rr_last got data=%h id=%0d exp 002 1", rsp_data, rsp_id); end
    req_valid = '0;
    #1;
    tick();
    checks++; if (busy !== 1'b0 || done_cnt !== 4'd6) begin errors++; $display("FAIL rr_done got busy=%b cnt=%0d exp 0 6", busy, done_cnt); end
  endtask

  task automatic test_backpressure();
    // ptr is 2 after the round-robin run
    req_data = {7'h00, 7'h2A, 7'h00, 7'h33};
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant got %b exp 0100", req_ready); end
    tick();
    req_valid = 4'b0001;
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 10'h02A || rsp_id !== 2'd2 || req_ready !== 4'b0000) begin errors++; $display("FAIL bp_hold%0d got valid=%b data=%h id=%0d rdy=%b exp 1 02a 2 0000", c, rsp_valid, rsp_data, rsp_id, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001 || rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_release got rdy=%b valid=%b exp 0001 1", req_ready, rsp_valid); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (done_cnt !== 4'd7 || clf_inp !== 7'h33 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_next got cnt=%0d inp=%h valid=%b exp 7 33 0", done_cnt, clf_inp, rsp_valid); end
    tick();
    checks++; if (rsp_data !== 10'h033 || rsp_id !== 2'd0) begin errors++; $display("FAIL bp_next_rsp got data=%h id=%0d exp 033 0", rsp_data, rsp_id); end
    tick();
  endtask

  task automatic test_withdrawn();
    do_reset();
    req_data = {7'h44, 7'h00, 7'h11, 7'h00};
    req_valid = 4'b1000;
    rsp_ready = 1'b0;
    tick();
    // requester 3 taken, ptr now 0; park in RESP with 1 and 3 pending
    req_data = {7'h55, 7'h00, 7'h11, 7'h00};
    req_valid = 4'b1010;
    tick();
    #1;
    checks++; if (req_ready !== 4'b0000 || rsp_id !== 2'd3) begin errors++; $display("FAIL wd_parked got rdy=%b id=%0d exp 0000 3", req_ready, rsp_id); end
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wd_skip got %b exp 1000", req_ready); end
    tick();
    req_valid = '0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 10'h055) begin errors++; $display("FAIL wd_rsp got valid=%b id=%0d data=%h exp 1 3 055", rsp_valid, rsp_id, rsp_data); end
    tick();
    checks++; if (done_cnt !== 4'd2) begin errors++; $display("FAIL wd_done got %0d exp 2", done_cnt); end
  endtask

  task automatic test_reset_mid_eval();
    req_data = {7'h00, 7'h00, 7'h00, 7'h66};
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    tick();
    req_valid = 4'b0001;
    #2;
    checks++; if (busy !== 1'b1 || clf_inp !== 7'h66) begin errors++; $display("FAIL rme_pre got busy=%b inp=%h exp 1 66", busy, clf_inp); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL rme_async got busy=%b valid=%b rdy=%b exp 0 0 0000", busy, rsp_valid, req_ready); end
    checks++; if (clf_inp !== 7'h00 || done_cnt !== 4'd0 || rsp_data !== 10'h000) begin errors++; $display("FAIL rme_regs got inp=%h cnt=%0d data=%h exp 0 0 0", clf_inp, done_cnt, rsp_data); end
    req_valid = '0;
    #2;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0 || done_cnt !== 4'd0) begin errors++; $display("FAIL rme_after%0d got valid=%b cnt=%0d exp 0 0", c, rsp_valid, done_cnt); end
    end
  endtask

  task automatic test_counter_wrap();
    int hs;
    int cyc;
    hs = 0;
    cyc = 0;
    req_data = {7'h00, 7'h00, 7'h00, 7'h01};
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    while (hs < 17 && cyc < 200) begin
      tick();
      cyc++;
      if (rsp_valid) begin
        hs++;
        if (hs == 17) begin
          req_valid = '0;
          checks++; if (done_cnt !== 4'd0) begin errors++; $display("FAIL wrap_16 got %0d exp 0", done_cnt); end
        end
      end
    end
    checks++; if (hs != 17) begin errors++; $display("FAIL wrap_timeout got %0d handshakes exp 17", hs); end
    tick();
    tick();
    checks++; if (done_cnt !== 4'd1 || busy !== 1'b0) begin errors++; $display("FAIL wrap_17 got cnt=%0d busy=%b exp 1 0", done_cnt, busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_withdrawn();
    test_reset_mid_eval();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
